ipg_axis_pkt_gen: RTL and testbench

- Upstream traffic source for the TX AXI-stream input of ipg_mac_phy_10g (tx_axis_*); runs in the tx_clk domain.
- Generates a programmable number of frames of programmable byte length, separated by a programmable idle gap, with a deterministic payload the RX side can check.
- Replaces hand-timed stimulus: it obeys tready backpressure, so MAC padding and IFG stalls need no manual delays.

---
 rtl/ipg_axis_pkt_gen_pkg.sv | 45 ++++
 rtl/ipg_axis_pkt_gen_if.sv | 33 +++
 rtl/ipg_axis_pkt_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_ipg_axis_pkt_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_axis_pkt_gen_pkg.sv
// Shared types and helpers for the AXI-stream frame generator.
// Holds the FSM state encoding, the payload field layout and the
// length/keep arithmetic used when a beat is built.
package ipg_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Payload layout: upper word carries the frame sequence number,
  // lower word the 1-based beat index within the frame.
  localparam int SEQ_LSB = 32;
  localparam int IDX_LSB = 0;
  localparam int FIELD_W = 32;

  // tkeep for the final beat given the byte count modulo 8.
  function automatic logic [7:0] last_keep(input logic [2:0] rem);
    if (rem == 3'd0) begin
      return 8'hFF;
    end
    return (8'h01 << rem) - 8'h01;
  endfunction

  // Number of 8-byte beats for a frame; an empty frame still sends one beat.
  function automatic logic [31:0] beats_of(input logic [31:0] len);
    if (len == 32'd0) begin
      return 32'd1;
    end
    return (len >> 3) + ((len[2:0] != 3'd0) ? 32'd1 : 32'd0);
  endfunction

  // Expand a byte-enable mask into a bit mask over the 64-bit beat.
  function automatic logic [63:0] keep_mask(input logic [7:0] keep);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ipg_axis_pkt_gen_if.sv
// AXI-stream bus between the frame generator and its sink (the MAC TX input).
interface ipg_axis_pkt_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/ipg_axis_pkt_gen.sv
// Programmable AXI-stream frame generator for the 10G MAC TX path.
// Emits cfg_pkt_count frames (0 = unlimited) of cfg_len_bytes bytes with
// cfg_gap_cycles idle cycles between them, honouring tready backpressure.
// Payload per beat: {sequence number, beat index}, unused tail bytes zeroed.
// Optional feature macro: IPG_PKTGEN_ERR_INJECT_EN adds an err_inject input
// that marks the last beat of the next frame with tuser[0]=1.
module ipg_axis_pkt_gen
  import ipg_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic                 enable,
  input  logic [LEN_WIDTH-1:0] cfg_len_bytes,
  input  logic [GAP_WIDTH-1:0] cfg_gap_cycles,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_count,
`ifdef IPG_PKTGEN_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  ipg_axis_pkt_gen_if.master   m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pkts_sent
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;      // clamped length of the frame in flight
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;  // beats in the frame in flight
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;      // 1-based index of the presented beat
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;      // idle cycles still to spend in GAP
  logic [CNT_WIDTH-1:0]  seq_q, seq_d;
  logic [CNT_WIDTH-1:0]  pkts_q, pkts_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
  logic                  err_arm_q, err_arm_d;
  logic                  tuser_q, tuser_d;
`endif

  logic                  start_frame;
  logic                  next_beat;
  logic                  is_last;
  logic [7:0]            keep_sel;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic [DATA_WIDTH-1:0] payload;

  // Next-state, counter and registered-output computation for the FSM.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beats_d     = beats_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    seq_d       = seq_q;
    pkts_d      = pkts_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    start_frame = 1'b0;
    next_beat   = 1'b0;
    is_last     = 1'b0;
    keep_sel    = 8'hFF;
    payload     = '0;
    eff_len     = (cfg_len_bytes == '0) ? LEN_WIDTH'(1) : cfg_len_bytes;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
    err_arm_d   = err_arm_q | err_inject;
    tuser_d     = tuser_q;
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          pkts_d      = '0;
          seq_d       = '0;
          start_frame = 1'b1;
          state_d     = SEND;
        end
      end

      SEND: begin
        if (tvalid_q && m_axis.tready) begin
          if (tlast_q) begin
            // Frame complete: account for it, then pick what follows.
            pkts_d   = pkts_q + 1'b1;
            seq_d    = seq_q + 1'b1;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
            tuser_d  = 1'b0;
`endif
            if ((cfg_pkt_count != '0) && (pkts_d == cfg_pkt_count)) begin
              state_d = DONE;
            end else if (!enable) begin
              state_d = IDLE;
            end else if (cfg_gap_cycles == '0) begin
              start_frame = 1'b1;
              state_d     = SEND;
            end else begin
              gap_d   = cfg_gap_cycles;
              state_d = GAP;
            end
          end else begin
            next_beat = 1'b1;
          end
        end
      end

      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAP_WIDTH'(1)) begin
          if (!enable) begin
            state_d = IDLE;
          end else begin
            start_frame = 1'b1;
            state_d     = SEND;
          end
        end
      end

      DONE: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      len_d   = eff_len;
      beats_d = LEN_WIDTH'(beats_of(32'(eff_len)));
      idx_d   = LEN_WIDTH'(1);
    end else if (next_beat) begin
      idx_d = idx_q + 1'b1;
    end

    // Build the beat that will be presented from the next cycle on.
    if (start_frame || next_beat) begin
      is_last  = (idx_d == beats_d);
      keep_sel = is_last ? last_keep(len_d[2:0]) : 8'hFF;
      payload[SEQ_LSB +: FIELD_W] = FIELD_W'(seq_d);
      payload[IDX_LSB +: FIELD_W] = FIELD_W'(idx_d);
      tdata_d  = payload & DATA_WIDTH'(keep_mask(keep_sel));
      tkeep_d  = KEEP_WIDTH'(keep_sel);
      tvalid_d = 1'b1;
      tlast_d  = is_last;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
      // The armed flag is consumed by whichever frame next loads its last beat.
      if (is_last) begin
        tuser_d   = err_arm_d;
        err_arm_d = 1'b0;
      end else begin
        tuser_d = 1'b0;
      end
`endif
    end

    busy_d = (state_d == SEND) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beats_q   <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      seq_q     <= '0;
      pkts_q    <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
      err_arm_q <= 1'b0;
      tuser_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beats_q   <= beats_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      seq_q     <= seq_d;
      pkts_q    <= pkts_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
      err_arm_q <= err_arm_d;
      tuser_q   <= tuser_d;
`endif
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
  assign m_axis.tuser  = USER_WIDTH'(tuser_q);
`else
  assign m_axis.tuser  = '0;
`endif
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkts_sent     = pkts_q;

endmodule

// File: tb/tb_ipg_axis_pkt_gen.sv
// Scoreboard bench for ipg_axis_pkt_gen: a frame-level model queues the
// expected beats, a monitor pops them on every handshake and also checks
// gap lengths and stall stability.
module tb_ipg_axis_pkt_gen;

  logic        tx_clk = 1'b0;
  logic        tx_rst;
  logic        enable;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_gap;
  logic [31:0] cfg_cnt;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
  logic        err_inject;
`endif

  ipg_axis_pkt_gen_if axis ();

  ipg_axis_pkt_gen dut (
    .tx_clk         (tx_clk),
    .tx_rst         (tx_rst),
    .enable         (enable),
    .cfg_len_bytes  (cfg_len),
    .cfg_gap_cycles (cfg_gap),
    .cfg_pkt_count  (cfg_cnt),
`ifdef IPG_PKTGEN_ERR_INJECT_EN
    .err_inject     (err_inject),
`endif
    .m_axis         (axis),
    .busy           (busy),
    .done           (done),
    .pkts_sent      (pkts_sent)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int          gap;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_fail = 0;
  int    ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: whole frames described by length, sequence and gap.
  task automatic push_frames(input int len, input int gap, input int nframes, input int err_frame);
    int          eff;
    int          beats;
    int          nbytes;
    beat_t       e;
    eff   = (len == 0) ? 1 : len;
    beats = (eff + 7) / 8;
    for (int f = 0; f < nframes; f++) begin
      for (int b = 1; b <= beats; b++) begin
        e.data = {32'(f), 32'(b)};
        e.keep = 8'h00;
        nbytes = (b < beats) ? 8 : eff - 8 * (beats - 1);
        for (int i = 0; i < 8; i++) begin
          if (i < nbytes) e.keep[i] = 1'b1;
          else            e.data[i*8 +: 8] = 8'h00;
        end
        e.last = (b == beats);
        e.user = (b == beats) && (f == err_frame);
        e.gap  = (b == 1 && f > 0) ? gap : -1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Sink readiness: always, alternating, or random.
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge tx_clk);
      #1;
      case (ready_mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ~axis.tready;
        default: axis.tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pop and compare on every handshake.
  initial begin
    beat_t       e;
    logic        pv;
    logic        pr;
    logic [63:0] pdata;
    logic [7:0]  pkeep;
    logic        plast;
    int          low_cnt;
    bit          after_last;
    pv = 1'b0; pr = 1'b0; pdata = '0; pkeep = '0; plast = 1'b0;
    low_cnt = 0; after_last = 1'b0;
    forever begin
      @(negedge tx_clk);
      if (tx_rst) begin
        pv = 1'b0; after_last = 1'b0; low_cnt = 0;
        continue;
      end
      if (pv && !pr) begin
        chk("stall_valid_held", {63'd0, axis.tvalid}, 64'd1);
        chk("stall_data_held", axis.tdata, pdata);
        chk("stall_keep_last_held", {55'd0, axis.tkeep, axis.tlast}, {55'd0, pkeep, plast});
      end
      if (axis.tvalid) begin
        if (after_last) begin
          after_last = 1'b0;
          if (exp_q.size() > 0 && exp_q[0].gap >= 0)
            chk("gap_cycles", 64'(low_cnt), 64'(exp_q[0].gap));
        end
        if (axis.tready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL extra_beat: got data %h, expected no beat", axis.tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", axis.tdata, e.data);
            chk("beat_keep", 64'(axis.tkeep), 64'(e.keep));
            chk("beat_last", 64'(axis.tlast), 64'(e.last));
            chk("beat_user", 64'(axis.tuser), 64'(e.user));
            if (axis.tlast) begin
              after_last = 1'b1;
              low_cnt = 0;
            end
          end
        end
      end else if (after_last) begin
        low_cnt++;
      end
      pv = axis.tvalid; pr = axis.tready;
      pdata = axis.tdata; pkeep = axis.tkeep; plast = axis.tlast;
    end
  end

  // Finite run: start, wait for done, check counters, release.
  task automatic run_finite(input int len, input int gap, input int cnt, input int mode,
                            input int err_frame);
    bit pulsed;
    pulsed = 1'b0;
    cfg_len = 16'(len); cfg_gap = 8'(gap); cfg_cnt = 32'(cnt); ready_mode = mode;
    push_frames(len, gap, cnt, err_frame);
    @(negedge tx_clk);
    enable = 1'b1;
    @(negedge tx_clk);
    chk("first_valid_latency", 64'(axis.tvalid), 64'd1);
    chk("busy_in_run", 64'(busy), 64'd1);
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge tx_clk);
`ifdef IPG_PKTGEN_ERR_INJECT_EN
      err_inject = 1'b0;
      if (!pulsed && err_frame >= 0 && axis.tvalid && axis.tdata[63:32] == 32'(err_frame)
          && axis.tdata[31:0] == 32'd1) begin
        err_inject = 1'b1;
        pulsed = 1'b1;
      end
`endif
    end
`ifdef IPG_PKTGEN_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    chk("done_reached", 64'(done), 64'd1);
    chk("pkts_sent_final", 64'(pkts_sent), 64'(cnt));
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge tx_clk);
    @(negedge tx_clk);
    chk("done_clears", 64'(done), 64'd0);
    chk("pkts_sent_hold", 64'(pkts_sent), 64'(cnt));
  endtask

  // Unlimited run stopped during beat 3 of frame 5.
  task automatic run_unlimited_stop();
    bit hit;
    int gap;
    hit = 1'b0;
    gap = $urandom_range(0, 3);
    cfg_len = 16'd64; cfg_gap = 8'(gap); cfg_cnt = 32'd0; ready_mode = 2;
    push_frames(64, gap, 6, -1);
    @(negedge tx_clk);
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge tx_clk);
      if (axis.tvalid && axis.tdata[63:32] == 32'd5 && axis.tdata[31:0] == 32'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("frame5_beat3_seen", 64'(hit), 64'd1);
    enable = 1'b0;
    for (int i = 0; i < 500 && busy; i++) @(negedge tx_clk);
    @(negedge tx_clk);
    chk("unl_pkts_sent", 64'(pkts_sent), 64'd6);
    chk("unl_done_low", 64'(done), 64'd0);
    chk("unl_busy_low", 64'(busy), 64'd0);
    chk("unl_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    tx_rst = 1'b1; enable = 1'b0;
    cfg_len = '0; cfg_gap = '0; cfg_cnt = '0;
`ifdef IPG_PKTGEN_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    repeat (3) @(negedge tx_clk);
    chk("rst_tvalid_tlast_tuser", {61'd0, axis.tvalid, axis.tlast, axis.tuser[0]}, 64'd0);
    chk("rst_tdata", axis.tdata, 64'd0);
    chk("rst_tkeep", 64'(axis.tkeep), 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_pkts_sent", 64'(pkts_sent), 64'd0);
    tx_rst = 1'b0;
    @(negedge tx_clk);

    run_finite(64, 0, 3, 0, -1);
    run_finite(13, 4, 2, 0, -1);
    run_finite(0, 0, 1, 0, -1);
    run_finite(64, 0, 1, 1, -1);
    for (int r = 0; r < 6; r++) begin
      run_finite($urandom_range(0, 100), $urandom_range(0, 6), $urandom_range(1, 4), 2, -1);
    end
    run_unlimited_stop();
`ifdef IPG_PKTGEN_ERR_INJECT_EN
    run_finite(20, 2, 3, 0, 1);
`endif

    // Reset in the middle of a frame.
    cfg_len = 16'd64; cfg_gap = 8'd0; cfg_cnt = 32'd2; ready_mode = 0;
    push_frames(64, 0, 2, -1);
    @(negedge tx_clk);
    enable = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tx_clk);
      if (axis.tvalid && axis.tdata[31:0] == 32'd4) begin
        hit = 1'b1;
        break;
      end
    end
    chk("midframe_beat4_seen", 64'(hit), 64'd1);
    #1 tx_rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("async_rst_tdata", axis.tdata, 64'd0);
    chk("async_rst_busy_pkts", {31'd0, busy, pkts_sent}, 64'd0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge tx_clk);
    tx_rst = 1'b0;
    repeat (3) @(negedge tx_clk);
    chk("post_rst_idle", 64'(axis.tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
